// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two cache clients, the arbiter and
// external memory.
//   c0_* : instruction-cache request/response channel (port 0)
//   c1_* : data-cache request/response channel (port 1)
//   mem_*: single word-granular external memory port
// Modports:
//   slave  - the arbiter side (takes client requests, drives memory)
//   master - the environment side (caches + memory model)
// Optional MEM_ARBITER_ERR_EN adds the sticky error flag o_err.
interface mem_arbiter_if;
    logic [31:0] i_c0_addr;
    logic        i_c0_ren;
    logic        i_c0_wen;
    logic [31:0] i_c0_wdata;
    logic        o_c0_ready;
    logic [31:0] o_c0_rdata;
    logic        o_c0_valid;

    logic [31:0] i_c1_addr;
    logic        i_c1_ren;
    logic        i_c1_wen;
    logic [31:0] i_c1_wdata;
    logic        o_c1_ready;
    logic [31:0] o_c1_rdata;
    logic        o_c1_valid;

    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
`ifdef MEM_ARBITER_ERR_EN
    logic        o_err;

    modport slave (
        input  i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
        output o_c0_ready, o_c0_rdata, o_c0_valid,
        input  i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
        output o_c1_ready, o_c1_rdata, o_c1_valid,
        input  i_mem_ready, i_mem_rdata, i_mem_valid,
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        output o_err
    );
    modport master (
        output i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
        input  o_c0_ready, o_c0_rdata, o_c0_valid,
        output i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
        input  o_c1_ready, o_c1_rdata, o_c1_valid,
        output i_mem_ready, i_mem_rdata, i_mem_valid,
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        input  o_err
    );
`else
    modport slave (
        input  i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
        output o_c0_ready, o_c0_rdata, o_c0_valid,
        input  i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
        output o_c1_ready, o_c1_rdata, o_c1_valid,
        input  i_mem_ready, i_mem_rdata, i_mem_valid,
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
    );
    modport master (
        output i_c0_addr, i_c0_ren, i_c0_wen, i_c0_wdata,
        input  o_c0_ready, o_c0_rdata, o_c0_valid,
        output i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata,
        input  o_c1_ready, o_c1_rdata, o_c1_valid,
        output i_mem_ready, i_mem_rdata, i_mem_valid,
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
    );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache = port 0, dcache = port 1) round-robin
// arbiter onto one external memory port, with an owner FIFO that steers
// in-order read responses back to the issuing cache. Request and response
// paths are purely combinational from registered state.
// Ports:
//   i_clk - clock
//   i_rst - asynchronous active-high reset
//   bus   - mem_arbiter_if.slave (client channels + memory port)
// Parameters: DEPTH outstanding reads (power of two), PW = log2(DEPTH).
// Optional: define MEM_ARBITER_ERR_EN to get the sticky bus.o_err flag.
module mem_arbiter #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {ST_FREE = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t         state, state_nx;
    logic           lock_owner, lock_owner_nx;
    logic           last_acc;
    logic           grant;
    logic [PW:0]    count;
    logic [PW-1:0]  wptr, rptr;
    logic [DEPTH-1:0] owner;

    logic req0, req1, g_ren, g_wen, g_req;
    logic full, empty, accept, push, pop, head;

    assign req0  = bus.i_c0_ren | bus.i_c0_wen;
    assign req1  = bus.i_c1_ren | bus.i_c1_wen;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // ---------------- lock FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_FREE;
            lock_owner <= 1'b0;
        end else begin
            state      <= state_nx;
            lock_owner <= lock_owner_nx;
        end
    end

    // ---------------- lock FSM: next state ----------------
    // Lock whenever the granted port is requesting but not taken, so the
    // memory-side request cannot change owner mid-handshake. A locked port
    // that drops its request simply releases the lock.
    always_comb begin
        state_nx      = ST_FREE;
        lock_owner_nx = lock_owner;
        if (g_req && !accept) begin
            state_nx      = ST_LOCK;
            lock_owner_nx = grant;
        end
    end

    // ---------------- lock FSM: output (grant) ----------------
    always_comb begin
        grant = ~last_acc;
        if (state == ST_LOCK)     grant = lock_owner;
        else if (req0 && !req1)   grant = 1'b0;
        else if (req1 && !req0)   grant = 1'b1;
    end

    // ---------------- memory drive / ready ----------------
    assign g_ren  = grant ? bus.i_c1_ren : bus.i_c0_ren;
    assign g_wen  = grant ? bus.i_c1_wen : bus.i_c0_wen;
    assign g_req  = g_ren | g_wen;
    assign accept = g_req & bus.i_mem_ready & ~full;
    assign push   = accept & g_ren;
    assign pop    = bus.i_mem_valid & ~empty;
    assign head   = owner[rptr];

    assign bus.o_mem_addr  = grant ? bus.i_c1_addr  : bus.i_c0_addr;
    assign bus.o_mem_wdata = grant ? bus.i_c1_wdata : bus.i_c0_wdata;
    assign bus.o_mem_ren   = g_ren & ~full;
    assign bus.o_mem_wen   = g_wen & ~full;
    assign bus.o_c0_ready  = bus.i_mem_ready & ~grant & ~full;
    assign bus.o_c1_ready  = bus.i_mem_ready &  grant & ~full;

    // rdata is broadcast; only valid is steered by the FIFO head.
    assign bus.o_c0_rdata  = bus.i_mem_rdata;
    assign bus.o_c1_rdata  = bus.i_mem_rdata;
    assign bus.o_c0_valid  = pop & ~head;
    assign bus.o_c1_valid  = pop &  head;

    // ---------------- last_acc + owner FIFO ----------------
    // last_acc resets to 1 so port 0 wins the first contention. Full is
    // taken from the registered count, so a same-cycle pop never frees a
    // slot for a same-cycle push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_acc <= 1'b1;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            owner    <= '0;
        end else begin
            if (accept) last_acc <= grant;
            if (push) begin
                owner[wptr] <= grant;
                wptr        <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MEM_ARBITER_ERR_EN
    logic err;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) err <= 1'b0;
        else if ((bus.i_mem_valid && empty) ||
                 (bus.i_c0_ren && bus.i_c0_wen) ||
                 (bus.i_c1_ren && bus.i_c1_wen) ||
                 (state == ST_LOCK && !g_req))
            err <= 1'b1;
    end
    assign bus.o_err = err;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.DEPTH(4), .PW(2)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0;
        logic        r1, w1;
        logic [31:0] a1;
        logic        mr, mv;
        logic [31:0] rd;
        logic        eg;                        // expected granted port
        logic        e0r, e1r, e0v, e1v, emr, emw;
    } vec_t;

    localparam logic [31:0] WD0 = 32'hC0DE_0000;
    localparam logic [31:0] WD1 = 32'h1234_5678;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rs, logic r0, logic w0, logic [31:0] a0,
                                logic r1, logic w1, logic [31:0] a1,
                                logic mr, logic mv, logic [31:0] rd, logic eg,
                                logic e0r, logic e1r, logic e0v, logic e1v,
                                logic emr, logic emw);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.mr = mr; v.mv = mv; v.rd = rd; v.eg = eg;
        v.e0r = e0r; v.e1r = e1r; v.e0v = e0v; v.e1v = e1v;
        v.emr = emr; v.emw = emw;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.i_c0_ren = v.r0; bus.i_c0_wen = v.w0; bus.i_c0_addr = v.a0; bus.i_c0_wdata = WD0;
        bus.i_c1_ren = v.r1; bus.i_c1_wen = v.w1; bus.i_c1_addr = v.a1; bus.i_c1_wdata = WD1;
        bus.i_mem_ready = v.mr; bus.i_mem_valid = v.mv; bus.i_mem_rdata = v.rd;
    endtask

    task automatic check(input int idx, input vec_t v);
        logic [5:0]  got_f, exp_f;
        logic [31:0] exp_a, exp_d;
        exp_a = v.eg ? v.a1 : v.a0;
        exp_d = v.eg ? WD1 : WD0;
        got_f = {bus.o_c0_ready, bus.o_c1_ready, bus.o_c0_valid, bus.o_c1_valid,
                 bus.o_mem_ren, bus.o_mem_wen};
        exp_f = {v.e0r, v.e1r, v.e0v, v.e1v, v.emr, v.emw};
        n_vec++;
        if (got_f !== exp_f || bus.o_mem_addr !== exp_a || bus.o_mem_wdata !== exp_d ||
            bus.o_c0_rdata !== v.rd || bus.o_c1_rdata !== v.rd) begin
            n_bad++;
            $display("FAIL vec%0d: rdy0/rdy1/vld0/vld1/ren/wen got %b want %b, addr got %h want %h, wdata got %h want %h, rdata %h/%h want %h",
                     idx, got_f, exp_f, bus.o_mem_addr, exp_a, bus.o_mem_wdata, exp_d,
                     bus.o_c0_rdata, bus.o_c1_rdata, v.rd);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    initial begin
        // rs r0 w0 a0        r1 w1 a1        mr mv rd            g  0r 1r 0v 1v mr mw
        vecs.push_back(mk(1, 0,0,32'h0,   0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,0,0)); // reset
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,0,0)); // idle
        vecs.push_back(mk(0, 1,0,32'h100, 0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0)); // p0 read
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,0,32'h0,        1, 0,1,0,0,0,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hDEADBEEF, 1, 0,1,1,0,0,0)); // resp -> p0
        vecs.push_back(mk(1, 0,0,32'h0,   0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,0,0)); // reset
        vecs.push_back(mk(0, 1,0,32'h10,  1,0,32'h20,  1,0,32'h0,        0, 1,0,0,0,1,0)); // contention 0,1,0,1
        vecs.push_back(mk(0, 1,0,32'h10,  1,0,32'h20,  1,0,32'h0,        1, 0,1,0,0,1,0));
        vecs.push_back(mk(0, 1,0,32'h10,  1,0,32'h20,  1,0,32'h0,        0, 1,0,0,0,1,0));
        vecs.push_back(mk(0, 1,0,32'h10,  1,0,32'h20,  1,0,32'h0,        1, 0,1,0,0,1,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hA,        0, 0,0,1,0,0,0)); // full, resp A
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hB,        0, 1,0,0,1,0,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hC,        0, 1,0,1,0,0,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hD,        0, 1,0,0,1,0,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,1,32'h200, 0,0,32'h0,        1, 0,0,0,0,0,1)); // p1 write stalled
        vecs.push_back(mk(0, 1,0,32'h300, 0,1,32'h200, 0,0,32'h0,        1, 0,0,0,0,0,1)); // locked
        vecs.push_back(mk(0, 1,0,32'h300, 0,1,32'h200, 0,0,32'h0,        1, 0,0,0,0,0,1));
        vecs.push_back(mk(0, 1,0,32'h300, 0,1,32'h200, 1,0,32'h0,        1, 0,1,0,0,0,1)); // accepted
        vecs.push_back(mk(0, 1,0,32'h300, 0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0)); // p0 next
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'h5,        1, 0,1,1,0,0,0)); // write not pushed
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1,0,32'h40, 0,0,32'h0, 1,0,32'h0,       0, 1,0,0,0,1,0)); // fill
        vecs.push_back(mk(0, 1,0,32'h40,  0,1,32'h240, 1,0,32'h0,        1, 0,0,0,0,0,0)); // full blocks both
        vecs.push_back(mk(0, 1,0,32'h40,  0,1,32'h240, 1,1,32'h6,        1, 0,0,1,0,0,0)); // pop, no bypass
        vecs.push_back(mk(0, 1,0,32'h40,  0,1,32'h240, 1,0,32'h0,        1, 0,1,0,0,0,1)); // write taken
        vecs.push_back(mk(0, 1,0,32'h40,  0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0));
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'h7,        1, 0,0,1,0,0,0)); // drain
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0,0,32'h0, 0,0,32'h0, 1,1,32'h8 + i,    1, 0,1,1,0,0,0));
        vecs.push_back(mk(0, 1,0,32'h50,  0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0)); // 2 outstanding
        vecs.push_back(mk(0, 1,0,32'h50,  0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0));
        vecs.push_back(mk(1, 0,0,32'h0,   0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,0,0)); // reset
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hE1,       0, 1,0,0,0,0,0)); // dropped
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hE2,       0, 1,0,0,0,0,0)); // dropped
        vecs.push_back(mk(0, 0,0,32'h0,   1,0,32'h60,  0,0,32'h0,        1, 0,0,0,0,1,0)); // p1 lock
        vecs.push_back(mk(0, 1,0,32'h70,  0,0,32'h60,  1,0,32'h0,        1, 0,1,0,0,0,0)); // p1 drops
        vecs.push_back(mk(0, 1,0,32'h70,  0,0,32'h0,   1,0,32'h0,        0, 1,0,0,0,1,0)); // resumes
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hF0,       1, 0,1,1,0,0,0));
        vecs.push_back(mk(0, 0,0,32'h0,   1,0,32'h80,  1,0,32'h0,        1, 0,1,0,0,1,0)); // p1 read
        vecs.push_back(mk(0, 1,0,32'h90,  0,0,32'h0,   1,1,32'hF1,       0, 1,0,0,1,1,0)); // push+pop
        vecs.push_back(mk(0, 0,0,32'h0,   0,0,32'h0,   1,1,32'hF2,       1, 0,1,1,0,0,0));

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check(i, vecs[i]);
        end

        // Asynchronous reset with the FIFO full: ready must return without a clock edge.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(mk(0, 1,0,32'h44, 0,0,32'h0, 1,0,32'h0, 0, 0,0,0,0,0,0));
        end
        @(posedge clk); #1;
        drive(mk(0, 0,0,32'h0, 0,0,32'h0, 1,0,32'h0, 0, 0,0,0,0,0,0));
        @(negedge clk);
        chk1("full_ready0", bus.o_c0_ready, 1'b0);
        chk1("full_ready1", bus.o_c1_ready, 1'b0);
        #2 rst = 1'b1;
        #1 chk1("async_rst_ready0", bus.o_c0_ready, 1'b1);
        chk1("async_rst_ready1", bus.o_c1_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        bus.i_mem_valid = 1'b1;
        @(negedge clk);
        chk1("late_resp_vld0", bus.o_c0_valid, 1'b0);
        chk1("late_resp_vld1", bus.o_c1_valid, 1'b0);

`ifdef MEM_ARBITER_ERR_EN
        @(posedge clk); #1;
        chk1("err_late_resp", bus.o_err, 1'b1);
        rst = 1'b1; bus.i_mem_valid = 1'b0;
        #1 chk1("err_reset", bus.o_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        bus.i_c1_ren = 1'b1; bus.i_c1_wen = 1'b1; bus.i_mem_ready = 1'b0;
        @(negedge clk);
        chk1("err_before_edge", bus.o_err, 1'b0);
        @(posedge clk); #1;
        bus.i_c1_ren = 1'b0; bus.i_c1_wen = 1'b0;
        chk1("err_renwen", bus.o_err, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("err_sticky", bus.o_err, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
